// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Round-robin arbiter and sequencer that gives N_REQ byte requesters shared
// access to the UART TX register file. For each granted byte it writes the TX
// data register, raises the start bit in the control register for exactly one
// cycle, then polls the status register until the transmission completes or
// the poll budget runs out. This block is the only master of the reg_file
// write/read port.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   req_valid  per-requester "byte available", held until req_ready
//   req_data   per-requester byte, requester k at [8k+7:8k]
//   req_ready  one-cycle pulse: byte of requester k accepted
//   req_done   one-cycle pulse: byte of requester k transmitted
//   req_err    one-cycle pulse: byte of requester k aborted on poll timeout
//   wr_en      reg_file write enable
//   wr_addr    0 = control register, 1 = TX data register
//   wr_data    reg_file write data
//   rd_en      reg_file read enable
//   rd_addr    1 = status register ({6'b0, done, busy})
//   rd_data    reg_file read data, valid the cycle after rd_en
//   active_id  index of the current grant, 0 when idle
//   arb_busy   high whenever the sequencer is not idle
//
// Every output is a flop, so there is no combinational input-to-output path.

module uart_tx_arbiter #(
    parameter int          N_REQ        = 2,
    parameter logic [7:0]  CTRL_START   = 8'h01,
    parameter int          POLL_TIMEOUT = 1023,
    localparam int         ID_W         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     req_done,
    output logic [N_REQ-1:0]     req_err,
    output logic                 wr_en,
    output logic                 wr_addr,
    output logic [7:0]           wr_data,
    output logic                 rd_en,
    output logic                 rd_addr,
    input  logic [7:0]           rd_data,
    output logic [ID_W-1:0]      active_id,
    output logic                 arb_busy
);

    typedef enum logic [3:0] {
        IDLE,
        GRANT,
        WR_DATA,
        WR_CTRL,
        CLR_CTRL,
        RD_STAT,
        WAIT_STAT,
        CHK_STAT,
        DONE,
        ERR
    } state_t;

    localparam logic [15:0] POLL_LIMIT = 16'(POLL_TIMEOUT);

    state_t          state;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] cur_id;
    logic [7:0]      cur_byte;
    logic [15:0]     poll_cnt;
    logic            seen_busy;

    // Only the done/busy bits of the status register carry meaning.
    logic rd_unused;
    assign rd_unused = ^rd_data[7:2];

    // Unpack the flat request bus into one byte per requester.
    logic [7:0] req_bytes [N_REQ];
    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign req_bytes[k] = req_data[8*k +: 8];
    end

    // Rotating-priority search: first valid requester after last_grant,
    // wrapping modulo N_REQ, so last_grant itself has lowest priority.
    logic [ID_W-1:0] pick_id;
    logic [ID_W-1:0] cand;
    logic            pick_found;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise a path that skips the assignment infers a latch.
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = ID_W'((int'(last_grant) + off) % N_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    // Status bits as sampled in CHK_STAT.
    logic stat_busy;
    logic stat_done;
    logic complete;
    assign stat_busy = rd_data[0];
    assign stat_done = rd_data[1];
    // Completion is either an explicit done, or busy falling after it was
    // seen high on an earlier poll of this byte.
    assign complete  = stat_done || (seen_busy && !stat_busy);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= ID_W'(N_REQ - 1);
            cur_id     <= '0;
            cur_byte   <= '0;
            poll_cnt   <= '0;
            seen_busy  <= 1'b0;
            req_ready  <= '0;
            req_done   <= '0;
            req_err    <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= 1'b0;
            wr_data    <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= 1'b0;
            active_id  <= '0;
            arb_busy   <= 1'b0;
        end else begin
            // NOTE: state and outputs are flops, so all assignments here are
            // non-blocking; later assignments in the same cycle win, which is
            // how the pulse defaults below get overridden per state.
            req_ready <= '0;
            req_done  <= '0;
            req_err   <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= 1'b0;
            wr_data   <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= 1'b0;

            // Each branch loads the outputs that belong to the state being
            // entered, so outputs line up with the registered state.
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state              <= GRANT;
                        cur_id             <= pick_id;
                        cur_byte           <= req_bytes[pick_id];
                        poll_cnt           <= '0;
                        seen_busy          <= 1'b0;
                        req_ready[pick_id] <= 1'b1;
                        active_id          <= pick_id;
                        arb_busy           <= 1'b1;
                    end
                end

                GRANT: begin
                    state   <= WR_DATA;
                    wr_en   <= 1'b1;
                    wr_addr <= 1'b1;
                    wr_data <= cur_byte;
                end

                WR_DATA: begin
                    state   <= WR_CTRL;
                    wr_en   <= 1'b1;
                    wr_addr <= 1'b0;
                    wr_data <= CTRL_START;
                end

                // Clearing control right after setting it makes start a
                // single-cycle level seen by the transmitter.
                WR_CTRL: begin
                    state   <= CLR_CTRL;
                    wr_en   <= 1'b1;
                    wr_addr <= 1'b0;
                    wr_data <= 8'h00;
                end

                CLR_CTRL: begin
                    state   <= RD_STAT;
                    rd_en   <= 1'b1;
                    rd_addr <= 1'b1;
                end

                RD_STAT: begin
                    state <= WAIT_STAT;
                end

                // reg_file read data is registered; this cycle absorbs it.
                WAIT_STAT: begin
                    state <= CHK_STAT;
                end

                CHK_STAT: begin
                    if (stat_busy) begin
                        seen_busy <= 1'b1;
                    end
                    if (complete) begin
                        state            <= DONE;
                        req_done[cur_id] <= 1'b1;
                    end else if (poll_cnt == POLL_LIMIT) begin
                        state           <= ERR;
                        req_err[cur_id] <= 1'b1;
                    end else begin
                        state    <= RD_STAT;
                        poll_cnt <= poll_cnt + 16'd1;
                        rd_en    <= 1'b1;
                        rd_addr  <= 1'b1;
                    end
                end

                DONE, ERR: begin
                    state      <= IDLE;
                    last_grant <= cur_id;
                    active_id  <= '0;
                    arb_busy   <= 1'b0;
                end

                default: begin
                    state     <= IDLE;
                    active_id <= '0;
                    arb_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//
// Self-checking bench for uart_tx_arbiter with two requesters. A behavioural
// reg_file answers status polls according to a per-transmission profile
// (done after N cycles, busy falling without done, or never finishing).
// Expected grants, register writes and done/err pulses are queued when the
// stimulus is posted and compared as the DUT produces them.

module tb_uart_tx_arbiter;

    localparam int N_REQ = 2;
    localparam int TMO   = 20;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [N_REQ-1:0]    req_valid = '0;
    logic [8*N_REQ-1:0]  req_data  = '0;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    req_done;
    logic [N_REQ-1:0]    req_err;
    logic                wr_en;
    logic                wr_addr;
    logic [7:0]          wr_data;
    logic                rd_en;
    logic                rd_addr;
    logic [7:0]          rd_data = '0;
    logic [0:0]          active_id;
    logic                arb_busy;

    uart_tx_arbiter #(
        .N_REQ        (N_REQ),
        .CTRL_START   (8'h01),
        .POLL_TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .req_done  (req_done),
        .req_err   (req_err),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .active_id (active_id),
        .arb_busy  (arb_busy)
    );

    always #5 clk = ~clk;

    typedef enum int {M_DONE, M_FALL, M_TMO} mode_e;
    typedef struct {
        mode_e mode;
        int    len;
    } stat_cfg_t;
    typedef struct packed {
        logic       is_err;
        logic [7:0] id;
    } evt_t;

    logic [7:0] src_q0 [$];
    logic [7:0] src_q1 [$];
    stat_cfg_t  cfg_q  [$];
    logic [8:0] wr_q   [$];
    int         grant_q[$];
    evt_t       evt_q  [$];

    int checks = 0;
    int errors = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- requesters: present queued bytes until accepted
    always @(negedge clk) begin
        if (req_ready[0] && req_valid[0] && src_q0.size() > 0) void'(src_q0.pop_front());
        if (req_ready[1] && req_valid[1] && src_q1.size() > 0) void'(src_q1.pop_front());
        req_valid[0]   = (src_q0.size() > 0);
        req_valid[1]   = (src_q1.size() > 0);
        req_data[7:0]  = (src_q0.size() > 0) ? src_q0[0] : 8'h00;
        req_data[15:8] = (src_q1.size() > 0) ? src_q1[0] : 8'h00;
    end

    // ---------------- behavioural reg_file
    logic      st_busy  = 1'b0;
    logic      st_done  = 1'b0;
    int        st_cnt   = 0;
    mode_e     cur_mode = M_DONE;
    logic [7:0] tx_reg  = '0;
    stat_cfg_t c_now;

    always @(posedge clk) begin
        if (rd_en && rd_addr) rd_data <= {6'b0, st_done, st_busy};
        if (wr_en && wr_addr) tx_reg <= wr_data;
        if (wr_en && !wr_addr && wr_data[0]) begin
            if (cfg_q.size() > 0) c_now = cfg_q.pop_front();
            else begin
                c_now.mode = M_DONE;
                c_now.len  = 0;
            end
            cur_mode <= c_now.mode;
            if (c_now.mode == M_TMO || c_now.len == 0) begin
                st_busy <= 1'b0;
                st_done <= (c_now.mode == M_DONE);
                st_cnt  <= 0;
            end else begin
                st_busy <= 1'b1;
                st_done <= 1'b0;
                st_cnt  <= c_now.len;
            end
        end else if (st_cnt > 0) begin
            st_cnt <= st_cnt - 1;
            if (st_cnt == 1) begin
                st_busy <= 1'b0;
                st_done <= (cur_mode == M_DONE);
            end
        end
    end

    // ---------------- monitor / scoreboard
    int   cyc = 0;
    int   grant_cyc = 0;
    int   last_end_cyc = 0;
    int   last_wr_cyc = 0;
    int   last_lat = 0;
    int   last_gap = 0;
    int   polls = 0;
    int   complete_polls = 0;
    logic mon_seen = 1'b0;
    logic rd_pend = 1'b0;

    always @(negedge clk) begin
        int   g;
        evt_t e;
        logic [8:0] w;
        logic [1:0] v;
        cyc++;
        check("wr_rd_exclusive", 32'(wr_en & rd_en), 0);

        // Status value returned for the read issued one cycle earlier.
        if (rd_pend) begin
            v = rd_data[1:0];
            polls++;
            if (v[1] || (mon_seen && !v[0])) complete_polls++;
            if (v[0]) mon_seen = 1'b1;
        end
        rd_pend = rd_en;

        if (req_ready != '0) begin
            if (grant_q.size() > 0) begin
                g = grant_q.pop_front();
                check("grant_ready", 32'(req_ready), 32'(1) << g);
                check("grant_active_id", 32'(active_id), g);
            end else begin
                check("unexpected_grant", 32'(req_ready), 0);
            end
            last_gap       = cyc - last_end_cyc;
            grant_cyc      = cyc;
            polls          = 0;
            complete_polls = 0;
            mon_seen       = 1'b0;
            rd_pend        = 1'b0;
        end

        if (wr_en) begin
            if (wr_q.size() > 0) begin
                w = wr_q.pop_front();
                check("reg_write", 32'({wr_addr, wr_data}), 32'(w));
            end else begin
                check("unexpected_write", 32'(wr_en), 0);
            end
            if (!wr_addr) check("ctrl_write_consecutive", cyc - last_wr_cyc, 1);
            last_wr_cyc = cyc;
        end

        if ((req_done | req_err) != '0) begin
            if (evt_q.size() > 0) begin
                e = evt_q.pop_front();
                check("evt_kind", 32'({req_err != '0, req_done != '0}), e.is_err ? 32'd2 : 32'd1);
                check("evt_requester", 32'(req_done | req_err), 32'(1) << e.id);
                check("evt_active_id", 32'(active_id), 32'(e.id));
                if (!e.is_err) begin
                    check("done_single_complete_poll", complete_polls, 1);
                end else begin
                    check("err_poll_count", polls, TMO + 1);
                    check("err_no_complete_poll", complete_polls, 0);
                end
            end else begin
                check("unexpected_done_err", 32'(req_done | req_err), 0);
            end
            last_lat     = cyc - grant_cyc;
            last_end_cyc = cyc;
        end
    end

    // ---------------- stimulus helpers
    task automatic add_cfg(mode_e m, int len);
        stat_cfg_t c;
        c.mode = m;
        c.len  = len;
        cfg_q.push_back(c);
    endtask

    task automatic expect_byte(int id, logic [7:0] b, bit is_err, bit has_evt);
        evt_t e;
        grant_q.push_back(id);
        wr_q.push_back({1'b1, b});
        wr_q.push_back({1'b0, 8'h01});
        wr_q.push_back({1'b0, 8'h00});
        e.is_err = is_err;
        e.id     = 8'(id);
        if (has_evt) evt_q.push_back(e);
    endtask

    task automatic drain(string tag, int budget);
        int n = 0;
        while ((grant_q.size() + wr_q.size() + evt_q.size()) > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drained"}, grant_q.size() + wr_q.size() + evt_q.size(), 0);
        repeat (3) @(negedge clk);
        check({tag, "_idle_busy"}, 32'(arb_busy), 0);
        check({tag, "_idle_id"}, 32'(active_id), 0);
    endtask

    // ---------------- directed sequence
    initial begin
        int n;

        // Reset dominance with both requesters valid.
        rst = 1'b0;
        expect_byte(0, 8'hA5, 1'b0, 1'b1);
        expect_byte(1, 8'hB6, 1'b0, 1'b1);
        add_cfg(M_DONE, 10);
        add_cfg(M_DONE, 0);
        src_q0.push_back(8'hA5);
        src_q1.push_back(8'hB6);
        repeat (20) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_req_done",  32'(req_done),  0);
        check("rst_req_err",   32'(req_err),   0);
        check("rst_wr",        32'({wr_en, wr_addr, wr_data}), 0);
        check("rst_rd",        32'({rd_en, rd_addr}), 0);
        check("rst_active_id", 32'(active_id), 0);
        check("rst_arb_busy",  32'(arb_busy),  0);

        // Release: requester 0 first (A5, busy then done), then B6 minimal.
        rst = 1'b1;
        drain("single", 300);
        check("min_latency", last_lat, 7);
        check("b2b_gap", last_gap, 2);

        // Round robin with both requesters continuously valid.
        expect_byte(0, 8'h11, 1'b0, 1'b1);
        expect_byte(1, 8'h22, 1'b0, 1'b1);
        expect_byte(0, 8'h11, 1'b0, 1'b1);
        expect_byte(1, 8'h22, 1'b0, 1'b1);
        repeat (4) add_cfg(M_DONE, 2);
        src_q0.push_back(8'h11);
        src_q0.push_back(8'h11);
        src_q1.push_back(8'h22);
        src_q1.push_back(8'h22);
        drain("round_robin", 400);
        check("rr_b2b_gap", last_gap, 2);
        check("rr_tx_reg_last", 32'(tx_reg), 32'h22);

        // Busy-fall completion without done.
        expect_byte(0, 8'h3C, 1'b0, 1'b1);
        add_cfg(M_FALL, 7);
        src_q0.push_back(8'h3C);
        drain("busy_fall", 300);

        // Timeout on requester 1; next grant goes to requester 0.
        expect_byte(1, 8'h44, 1'b1, 1'b1);
        expect_byte(0, 8'h55, 1'b0, 1'b1);
        expect_byte(1, 8'h66, 1'b0, 1'b1);
        add_cfg(M_TMO, 0);
        add_cfg(M_DONE, 1);
        add_cfg(M_DONE, 1);
        src_q1.push_back(8'h44);
        src_q1.push_back(8'h66);
        src_q0.push_back(8'h55);
        drain("timeout", 600);

        // Leave last_grant at requester 0.
        expect_byte(0, 8'h70, 1'b0, 1'b1);
        add_cfg(M_DONE, 1);
        src_q0.push_back(8'h70);
        drain("pre_midop", 200);

        // Mid-transaction reset during RD_STAT: no done, restart at requester 0.
        expect_byte(0, 8'h77, 1'b0, 1'b0);
        add_cfg(M_FALL, 50);
        src_q0.push_back(8'h77);
        n = 0;
        while (!rd_en && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midop_reached_rd_stat", 32'(rd_en), 1);
        #2 rst = 1'b0;
        #1;
        check("midop_rd_en_drop",   32'(rd_en),    0);
        check("midop_arb_busy",     32'(arb_busy), 0);
        check("midop_active_id",    32'(active_id), 0);
        check("midop_pulses",       32'({req_ready, req_done, req_err}), 0);
        check("midop_wr_en",        32'(wr_en), 0);
        expect_byte(0, 8'h88, 1'b0, 1'b1);
        expect_byte(1, 8'h99, 1'b0, 1'b1);
        add_cfg(M_DONE, 1);
        add_cfg(M_DONE, 1);
        src_q0.push_back(8'h88);
        src_q1.push_back(8'h99);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        drain("post_reset", 300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
